dsram_responder: RTL

- Memory-side responder for the data SRAM request interface that the dtlb stage drives: `data_sram_en`, `wen`, `sel`, `addr` and `wdata`.
- Converts each pipeline request into one transaction on a valid/ready request channel plus a valid-only response channel.
- Returns read data to the pipeline and raises `stallreq` until the transaction completes.
- Single outstanding transaction; sits between the dtlb/dt pipeline stages and the data bus interconnect.

---
 rtl/dsram_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dsram_responder.sv
// Purpose : memory-side responder turning dtlb data-SRAM requests into one bus transaction each.
// Latency : 4 cycles minimum per access (accept, REQ, WAIT, DONE); stallreq held until DONE.
// Backpress: request held stable on bus_req_* until bus_req_ready; single outstanding transaction.
//
// Ports:
//   clk, rst (async active-low), flush         - clock, reset, pipeline flush
//   data_sram_en/wen/sel/addr/wdata            - pipeline request
//   data_sram_rdata, stallreq                  - registered load data, pipeline stall
//   bus_req_valid/ready/wr/strb/size/addr/wdata - valid/ready request channel
//   bus_resp_valid, bus_resp_data              - valid-only response channel
//   bus_timeout                                - one-cycle pulse during a forced completion
module dsram_responder #(
    parameter int unsigned TIMEOUT  = 1023,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        data_sram_en,
    input  logic        data_sram_wen,
    input  logic [3:0]  data_sram_sel,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_wr,
    output logic [3:0]  bus_req_strb,
    output logic [1:0]  bus_req_size,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_resp_data,
    output logic        bus_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Last WAIT count before a forced completion; unused when TIMEOUT is 0.
    localparam logic [31:0] TMO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic        wr_q, wr_d;
    logic [3:0]  strb_q, strb_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tmo_q, tmo_d;

    // Store size from byte enables: aligned halves are size 1, single bytes size 0,
    // everything else (full word or irregular masks) goes out as a word with strobes.
    function automatic logic [1:0] store_size(input logic [3:0] sel);
        case (sel)
            4'b0011, 4'b1100:                   store_size = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: store_size = 2'd0;
            default:                            store_size = 2'd2;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        wr_d    = wr_q;
        strb_d  = strb_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        tmo_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (data_sram_en && !flush) begin
                    state_d = S_REQ;
                    valid_d = 1'b1;
                    wr_d    = data_sram_wen;
                    strb_d  = data_sram_wen ? data_sram_sel : 4'b0000;
                    size_d  = data_sram_wen ? store_size(data_sram_sel) : 2'd2;
                    addr_d  = data_sram_addr;
                    wdata_d = data_sram_wdata;
                end
            end
            S_REQ: begin
                // Flush is deliberately ignored here: valid is never withdrawn.
                if (bus_req_ready) begin
                    state_d = S_WAIT;
                    valid_d = 1'b0;
                    cnt_d   = 32'd0;
                end
            end
            S_WAIT: begin
                if (bus_resp_valid) begin
                    if (!wr_q) rdata_d = bus_resp_data;
                    state_d = S_DONE;
                end else if (TIMEOUT != 0 && cnt_q == TMO_LAST) begin
                    if (!wr_q) rdata_d = ERR_DATA;
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DONE: begin
                // The pipeline still shows the completed request this cycle; do not re-latch it.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            strb_q  <= 4'b0000;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 32'd0;
            rdata_q <= 32'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            wr_q    <= wr_d;
            strb_q  <= strb_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus_req_valid   = valid_q;
    assign bus_req_wr      = wr_q;
    assign bus_req_strb    = strb_q;
    assign bus_req_size    = size_q;
    assign bus_req_addr    = addr_q;
    assign bus_req_wdata   = wdata_q;
    assign data_sram_rdata = rdata_q;
    assign bus_timeout     = tmo_q;

    // Stall from the accepting cycle until the transaction reaches DONE.
    assign stallreq = ((state_q == S_IDLE) && data_sram_en && !flush)
                    || (state_q == S_REQ) || (state_q == S_WAIT);

endmodule
